// File: rtl/test_ctrl_pkg.sv
// Shared types and sizing helpers for the run controller and its compare pipeline.
package test_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic {
    TGT_RF = 1'b0,
    TGT_DM = 1'b1
  } tgt_t;

  // Bits needed to index n entries (0..n-1); never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count 0..n; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/test_run_ctrl_if.sv
// Core-facing bundle: reset/done handshake, register-file preload port and readback port.
interface test_run_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  import test_ctrl_pkg::*;

  logic          CoreReset;
  logic          CoreDone;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  tgt_t          rd_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output CoreReset, rf_we, rf_waddr, rf_wdata, rd_sel, rd_addr,
    input  CoreDone, rd_data
  );

  modport slave (
    input  CoreReset, rf_we, rf_waddr, rf_wdata, rd_sel, rd_addr,
    output CoreDone, rd_data
  );

endinterface

// File: rtl/test_run_ctrl_checker.sv
// Readback compare pipeline: aligns each check with its returning rd_data and keeps
// the mismatch count and the index of the lowest failing check.
module run_checker
  import test_ctrl_pkg::*;
#(
  parameter  int DW      = 8,
  parameter  int N_CHECK = 4,
  localparam int EW      = cnt_w(N_CHECK),
  localparam int FW      = idx_w(N_CHECK)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          valid,
  input  logic [FW-1:0] index,
  input  logic [DW-1:0] expected,
  input  logic [DW-1:0] rd_data,
  output logic          mismatch,
  output logic [EW-1:0] err_count,
  output logic [FW-1:0] first_fail
);

  logic          s_vld;
  logic [FW-1:0] s_idx;
  logic [DW-1:0] s_exp;

  // The stage register lines each check up with the read data that returns a cycle later.
  assign mismatch = s_vld && (rd_data != s_exp);

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      s_vld      <= 1'b0;
      s_idx      <= '0;
      s_exp      <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      s_vld <= valid;
      s_idx <= index;
      s_exp <= expected;
      if (mismatch) begin
        if (err_count != EW'(N_CHECK)) err_count <= err_count + 1'b1;
        if (err_count == '0)           first_fail <= s_idx;
      end
    end
  end

endmodule

// File: rtl/test_run_ctrl.sv
// Run controller for the single-cycle core: preload the register file, hold and release
// core reset, wait for Done with a timeout, then read back and check a list of locations.
module test_run_ctrl
  import test_ctrl_pkg::*;
#(
  parameter  int AW       = 8,
  parameter  int DW       = 8,
  parameter  int N_INIT   = 4,
  parameter  int N_CHECK  = 4,
  parameter  int RST_HOLD = 2,
  parameter  int TIMEOUT  = 1024,
  localparam int EW       = cnt_w(N_CHECK),
  localparam int FW       = idx_w(N_CHECK),
  localparam int CW       = cnt_w(TIMEOUT)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [N_INIT*AW-1:0]  init_addr,
  input  logic [N_INIT*DW-1:0]  init_data,
  input  logic [N_CHECK-1:0]    chk_sel,
  input  logic [N_CHECK*AW-1:0] chk_addr,
  input  logic [N_CHECK*DW-1:0] chk_data,
  test_run_ctrl_if.master       core,
  output logic                  Busy,
  output logic                  Pass,
  output logic                  Fail,
  output logic                  TimedOut,
  output logic [EW-1:0]         ErrCount,
  output logic [FW-1:0]         FirstFail,
  output logic [CW-1:0]         Cycles
);

  localparam int PW = idx_w(N_INIT);
  localparam int HW = idx_w(RST_HOLD);
  localparam int KW = cnt_w(N_CHECK + 1);

  state_t        state;
  logic [PW-1:0] pidx;
  logic [PW-1:0] pnext;
  logic [HW-1:0] hcnt;
  logic [KW-1:0] cidx;
  logic [KW-1:0] iss;
  logic [CW-1:0] cyc_inc;
  logic          chk_vld;
  logic [FW-1:0] chk_idx;
  logic [DW-1:0] chk_exp;
  logic          start_go;
  logic          mismatch;
  logic          last_ok;

  assign start_go = Start && (state == S_IDLE || state == S_DONE);
  assign pnext    = pidx + 1'b1;
  // Check 0 is issued on the Done edge itself, before the FSM has reached CHECK.
  assign iss      = (state == S_CHECK) ? cidx : '0;
  assign cyc_inc  = Cycles + 1'b1;
  // The verdict edge coincides with the last compare, so fold that compare in directly.
  assign last_ok  = (ErrCount == '0) && !mismatch;

  // NOTE: all state here is updated with <= so each flop sees pre-edge values; the reset
  // is synchronous and therefore handled as the first branch inside the clocked block.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= S_IDLE;
      pidx           <= '0;
      hcnt           <= '0;
      cidx           <= '0;
      chk_vld        <= 1'b0;
      chk_idx        <= '0;
      chk_exp        <= '0;
      core.CoreReset <= 1'b1;
      core.rf_we     <= 1'b0;
      core.rf_waddr  <= '0;
      core.rf_wdata  <= '0;
      core.rd_sel    <= TGT_RF;
      core.rd_addr   <= '0;
      Busy           <= 1'b0;
      Pass           <= 1'b0;
      Fail           <= 1'b0;
      TimedOut       <= 1'b0;
      Cycles         <= '0;
    end else begin
      chk_vld <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state          <= S_PRELOAD;
            pidx           <= '0;
            core.CoreReset <= 1'b1;
            core.rf_we     <= 1'b1;
            core.rf_waddr  <= init_addr[0 +: AW];
            core.rf_wdata  <= init_data[0 +: DW];
            core.rd_sel    <= TGT_RF;
            core.rd_addr   <= '0;
            Busy           <= 1'b1;
            Pass           <= 1'b0;
            Fail           <= 1'b0;
            TimedOut       <= 1'b0;
            Cycles         <= '0;
          end
        end

        S_PRELOAD: begin
          if (pidx == PW'(N_INIT - 1)) begin
            core.rf_we <= 1'b0;
            hcnt       <= '0;
            state      <= S_HOLD;
          end else begin
            pidx          <= pnext;
            core.rf_waddr <= init_addr[pnext*AW +: AW];
            core.rf_wdata <= init_data[pnext*DW +: DW];
          end
        end

        S_HOLD: begin
          if (hcnt == HW'(RST_HOLD - 1)) begin
            core.CoreReset <= 1'b0;
            state          <= S_RUN;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        S_RUN: begin
          Cycles <= cyc_inc;
          if (core.CoreDone) begin
            state        <= S_CHECK;
            cidx         <= KW'(1);
            core.rd_sel  <= tgt_t'(chk_sel[iss]);
            core.rd_addr <= chk_addr[iss*AW +: AW];
            chk_vld      <= 1'b1;
            chk_idx      <= FW'(iss);
            chk_exp      <= chk_data[iss*DW +: DW];
          end else if (cyc_inc == CW'(TIMEOUT)) begin
            TimedOut       <= 1'b1;
            Fail           <= 1'b1;
            Busy           <= 1'b0;
            core.CoreReset <= 1'b1;
            state          <= S_DONE;
          end
        end

        S_CHECK: begin
          if (cidx < KW'(N_CHECK)) begin
            cidx         <= cidx + 1'b1;
            core.rd_sel  <= tgt_t'(chk_sel[iss]);
            core.rd_addr <= chk_addr[iss*AW +: AW];
            chk_vld      <= 1'b1;
            chk_idx      <= FW'(iss);
            chk_exp      <= chk_data[iss*DW +: DW];
          end else if (cidx == KW'(N_CHECK)) begin
            cidx <= cidx + 1'b1;
          end else begin
            Pass           <= last_ok;
            Fail           <= !last_ok;
            Busy           <= 1'b0;
            core.CoreReset <= 1'b1;
            state          <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  run_checker #(
    .DW      (DW),
    .N_CHECK (N_CHECK)
  ) u_checker (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      (start_go),
    .valid      (chk_vld),
    .index      (chk_idx),
    .expected   (chk_exp),
    .rd_data    (core.rd_data),
    .mismatch   (mismatch),
    .err_count  (ErrCount),
    .first_fail (FirstFail)
  );

endmodule

// File: tb/tb_test_run_ctrl.sv
// Bench for test_run_ctrl: a small core/memory model, a vector table of whole runs with a
// result scoreboard, and hand-written sequences for reset, ignored events and back-to-back runs.
module tb_test_run_ctrl;
  import test_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NI = 2;
  localparam int NC = 4;
  localparam int RH = 2;
  localparam int TO = 16;
  localparam int EW = cnt_w(NC);
  localparam int FW = idx_w(NC);
  localparam int CW = cnt_w(TO);

  logic               Clk = 1'b0;
  logic               Reset;
  logic               Start;
  logic [NI*AW-1:0]   init_addr;
  logic [NI*DW-1:0]   init_data;
  logic [NC-1:0]      chk_sel;
  logic [NC*AW-1:0]   chk_addr;
  logic [NC*DW-1:0]   chk_data;
  logic               Busy, Pass, Fail, TimedOut;
  logic [EW-1:0]      ErrCount;
  logic [FW-1:0]      FirstFail;
  logic [CW-1:0]      Cycles;

  test_run_ctrl_if #(.AW(AW), .DW(DW)) core ();

  test_run_ctrl #(
    .AW(AW), .DW(DW), .N_INIT(NI), .N_CHECK(NC), .RST_HOLD(RH), .TIMEOUT(TO)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .init_addr (init_addr),
    .init_data (init_data),
    .chk_sel   (chk_sel),
    .chk_addr  (chk_addr),
    .chk_data  (chk_data),
    .core      (core),
    .Busy      (Busy),
    .Pass      (Pass),
    .Fail      (Fail),
    .TimedOut  (TimedOut),
    .ErrCount  (ErrCount),
    .FirstFail (FirstFail),
    .Cycles    (Cycles)
  );

  always #5 Clk = ~Clk;

  // Core model: done after `lat` run cycles (0 = never); on done the "program" copies
  // RF[0..15] into DM[0..15]. Readback is registered, one cycle after rd_addr.
  logic [DW-1:0] rf [256];
  logic [DW-1:0] dm [256];
  int            run_cnt;
  int            lat;
  logic          done_force;

  assign core.CoreDone = done_force || (!core.CoreReset && lat != 0 && run_cnt == lat - 1);

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) begin
        rf[i] <= '0;
        dm[i] <= '0;
      end
    end else begin
      if (core.rf_we) rf[core.rf_waddr] <= core.rf_wdata;
      if (core.CoreDone && !core.CoreReset)
        for (int i = 0; i < 16; i++) dm[i] <= rf[i];
    end
    run_cnt      <= core.CoreReset ? 0 : run_cnt + 1;
    core.rd_data <= (core.rd_sel == TGT_DM) ? dm[core.rd_addr] : rf[core.rd_addr];
  end

  typedef struct {
    logic [NI*AW-1:0] ia;
    logic [NI*DW-1:0] id;
    logic [NC-1:0]    cs;
    logic [NC*AW-1:0] ca;
    logic [NC*DW-1:0] cd;
    int               lat;
    bit               pass;
    bit               tout;
    int               err;
    int               ff;
    int               cyc;
  } vec_t;

  typedef struct {
    bit pass;
    bit tout;
    int err;
    int ff;
    int cyc;
  } exp_t;

  vec_t vecs [5];
  vec_t b2b;
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    init_addr = v.ia;
    init_data = v.id;
    chk_sel   = v.cs;
    chk_addr  = v.ca;
    chk_data  = v.cd;
    lat       = v.lat;
  endtask

  task automatic push_exp(input vec_t v);
    sb.push_back('{pass: v.pass, tout: v.tout, err: v.err, ff: v.ff, cyc: v.cyc});
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Wait (bounded) for the run to finish, then pop the scoreboard and compare the verdict.
  task automatic wait_and_compare(input bit chk_hold, input bit chk_noread);
    exp_t e;
    int   n = 0, hi = 0, rd_act = 0;
    bit   fell = 1'b0;
    while (Busy && n < 200) begin
      if (!fell && core.CoreReset) hi++;
      else fell = 1'b1;
      if (core.rd_addr != '0) rd_act++;
      @(negedge Clk);
      n++;
    end
    check("run_finished", Busy, 0);
    if (chk_hold)   check("core_reset_hold", hi, NI + RH);
    if (chk_noread) check("no_readback", rd_act, 0);
    e = sb.pop_front();
    check("pass",      Pass,           e.pass);
    check("fail",      Fail,           !e.pass);
    check("timed_out", TimedOut,       e.tout);
    check("err_count", ErrCount,       e.err);
    check("first_fail",FirstFail,      e.ff);
    check("cycles",    Cycles,         e.cyc);
    check("done_rst",  core.CoreReset, 1);
  endtask

  task automatic run_vec(input vec_t v);
    apply(v);
    push_exp(v);
    pulse_start();
    check("first_we",    core.rf_we,    1);
    check("first_waddr", core.rf_waddr, v.ia[AW-1:0]);
    check("first_wdata", core.rf_wdata, v.id[DW-1:0]);
    check("clr_busy",    Busy,          1);
    check("clr_pass",    Pass,          0);
    check("clr_fail",    Fail,          0);
    check("clr_tout",    TimedOut,      0);
    check("clr_err",     ErrCount,      0);
    check("clr_cycles",  Cycles,        0);
    wait_and_compare(1'b1, v.tout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Beq-style: r0=0, r1=1; RF[0]==0, RF[1]==1, DM[1]==1, DM[0]==0; done after 5 cycles.
    vecs[0] = '{ia: {8'd1, 8'd0}, id: {8'd1, 8'd0}, cs: 4'b1100,
                ca: {8'd0, 8'd1, 8'd1, 8'd0}, cd: {8'd0, 8'd1, 8'd1, 8'd0},
                lat: 5, pass: 1, tout: 0, err: 0, ff: 0, cyc: 5};
    // Checks 1 (RF[1]==8, is 7) and 3 (DM[0]==4, is 3) wrong.
    vecs[1] = '{ia: {8'd1, 8'd0}, id: {8'd7, 8'd3}, cs: 4'b1100,
                ca: {8'd0, 8'd1, 8'd1, 8'd0}, cd: {8'd4, 8'd7, 8'd8, 8'd3},
                lat: 3, pass: 0, tout: 0, err: 2, ff: 1, cyc: 3};
    // Never done: timeout at 16, no readback.
    vecs[2] = '{ia: {8'd3, 8'd4}, id: {8'd33, 8'd44}, cs: 4'b0000,
                ca: {8'd3, 8'd3, 8'd4, 8'd4}, cd: {8'd33, 8'd33, 8'd44, 8'd44},
                lat: 0, pass: 0, tout: 1, err: 0, ff: 0, cyc: 16};
    // Done on first run cycle; only the last check (DM[5]==0, is AA) wrong.
    vecs[3] = '{ia: {8'd5, 8'd4}, id: {8'hAA, 8'h55}, cs: 4'b1100,
                ca: {8'd5, 8'd4, 8'd5, 8'd4}, cd: {8'h00, 8'h55, 8'hAA, 8'h55},
                lat: 1, pass: 0, tout: 0, err: 1, ff: 3, cyc: 1};
    // Done exactly on the timeout cycle (done wins); every check wrong.
    vecs[4] = '{ia: {8'd7, 8'd6}, id: {8'd2, 8'd1}, cs: 4'b1100,
                ca: {8'd7, 8'd6, 8'd7, 8'd6}, cd: {8'd9, 8'd9, 8'd0, 8'd0},
                lat: 16, pass: 0, tout: 0, err: 4, ff: 0, cyc: 16};
    // Duplicate preload of address 2 (5 then 9); all checks expect 9.
    b2b     = '{ia: {8'd2, 8'd2}, id: {8'd9, 8'd5}, cs: 4'b1010,
                ca: {8'd2, 8'd2, 8'd2, 8'd2}, cd: {8'd9, 8'd9, 8'd9, 8'd9},
                lat: 2, pass: 1, tout: 0, err: 0, ff: 0, cyc: 2};

    Reset = 1'b1;
    Start = 1'b0;
    done_force = 1'b0;
    apply(vecs[0]);
    repeat (3) @(negedge Clk);
    check("rst_core_reset", core.CoreReset, 1);
    check("rst_rf_we",      core.rf_we,     0);
    check("rst_rf_waddr",   core.rf_waddr,  0);
    check("rst_rf_wdata",   core.rf_wdata,  0);
    check("rst_rd_sel",     core.rd_sel,    0);
    check("rst_rd_addr",    core.rd_addr,   0);
    check("rst_busy",       Busy,           0);
    check("rst_pass",       Pass,           0);
    check("rst_fail",       Fail,           0);
    check("rst_tout",       TimedOut,       0);
    check("rst_err",        ErrCount,       0);
    check("rst_ff",         FirstFail,      0);
    check("rst_cycles",     Cycles,         0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_core_reset", core.CoreReset, 1);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset mid-run at Cycles==3, then a clean run.
    apply(vecs[0]);
    lat = 10;
    pulse_start();
    for (int n = 0; n < 100 && Cycles != CW'(3); n++) @(negedge Clk);
    check("midrun_cycles3", Cycles, 3);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mr_busy",       Busy,           0);
    check("mr_core_reset", core.CoreReset, 1);
    check("mr_pass",       Pass,           0);
    check("mr_fail",       Fail,           0);
    check("mr_err",        ErrCount,       0);
    check("mr_cycles",     Cycles,         0);
    check("mr_rf_we",      core.rf_we,     0);
    run_vec(vecs[0]);

    // Done during HOLD is ignored; Start during RUN is ignored.
    apply(vecs[3]);
    lat = 6;
    sb.push_back('{pass: 0, tout: 0, err: 1, ff: 3, cyc: 6});
    pulse_start();
    @(negedge Clk);
    @(negedge Clk);
    done_force = 1'b1;
    check("hold_core_reset", core.CoreReset, 1);
    @(negedge Clk);
    check("hold_busy", Busy, 1);
    @(negedge Clk);
    done_force = 1'b0;
    check("run1_no_check", core.rd_addr,   0);
    check("run1_released", core.CoreReset, 0);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("late_start_busy",    Busy,           1);
    check("late_start_running", core.CoreReset, 0);
    wait_and_compare(1'b0, 1'b0);

    // Back-to-back from a failing DONE.
    run_vec(b2b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
